// File: rtl/alu_regfile_pkg.sv
// Shared opcode encodings and default widths for the ALU/register-file block.
package alu_regfile_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 3;

    typedef enum logic [3:0] {
        OP_PASS  = 4'b0000,
        OP_LOADI = 4'b0001,
        OP_ADD   = 4'b0010,
        OP_SUB   = 4'b0011,
        OP_AND   = 4'b0100,
        OP_OR    = 4'b0101,
        OP_XOR   = 4'b0110,
        OP_NOT   = 4'b0111,
        OP_SHL   = 4'b1001,
        OP_SHR   = 4'b1010
    } alu_op_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: result and zero flag from opcode and two operands.
module alu_core
    import alu_regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [3:0]        opcode,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result,
    output logic              zero
);

    logic [3:0] shamt;

    assign shamt = b[3:0];

    // Undefined opcodes fall through to operand a.
    always_comb begin
        result = a;
        unique case (opcode)
            OP_LOADI: result = b;
            OP_ADD:   result = a + b;
            OP_SUB:   result = a - b;
            OP_AND:   result = a & b;
            OP_OR:    result = a | b;
            OP_XOR:   result = a ^ b;
            OP_NOT:   result = ~a;
            OP_SHL:   result = a << shamt;
            OP_SHR:   result = a >> shamt;
            default:  result = a;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/alu_regfile.sv
// Eight-entry register file with two combinational read ports feeding alu_core.
module alu_regfile
    import alu_regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        opcode,
    input  logic [ADDR_W-1:0] address_a,
    input  logic [ADDR_W-1:0] address_b,
    input  logic              write_enable,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] data_a,
    output logic [DATA_W-1:0] data_b,
    output logic [DATA_W-1:0] alu_result,
    output logic              zero
);

    localparam int NREGS = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [NREGS];

    // Reset clears storage asynchronously, so reads see zero at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (write_enable) begin
            regs[address_a] <= write_data;
        end
    end

    assign data_a = regs[address_a];
    assign data_b = regs[address_b];

    alu_core #(
        .DATA_W (DATA_W)
    ) u_alu_core (
        .opcode (opcode),
        .a      (data_a),
        .b      (data_b),
        .result (alu_result),
        .zero   (zero)
    );

endmodule

// File: tb/tb_alu_regfile.sv
// Directed and randomized checks of alu_regfile against a behavioural model.
`timescale 1ns/100ps
module tb_alu_regfile;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  opcode;
    logic [2:0]  address_a;
    logic [2:0]  address_b;
    logic        write_enable;
    logic [15:0] write_data;
    logic [15:0] data_a;
    logic [15:0] data_b;
    logic [15:0] alu_result;
    logic        zero;

    int passed = 0;
    int total  = 0;

    logic [15:0] model [8];

    always #5 clk = ~clk;

    alu_regfile #(
        .DATA_W (16),
        .ADDR_W (3)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .opcode       (opcode),
        .address_a    (address_a),
        .address_b    (address_b),
        .write_enable (write_enable),
        .write_data   (write_data),
        .data_a       (data_a),
        .data_b       (data_b),
        .alu_result   (alu_result),
        .zero         (zero)
    );

    function automatic logic [15:0] ref_alu(input logic [3:0] op,
                                            input logic [15:0] a,
                                            input logic [15:0] b);
        int sh;
        sh = b % 16;
        case (op)
            4'd1:    return b;
            4'd2:    return 16'((32'(a) + 32'(b)) % 65536);
            4'd3:    return 16'((32'(a) + 65536 - 32'(b)) % 65536);
            4'd4:    return a & b;
            4'd5:    return a | b;
            4'd6:    return a ^ b;
            4'd7:    return 16'(65535 - 32'(a));
            4'd9:    return 16'((32'(a) * (32'd1 << sh)) % 65536);
            4'd10:   return 16'(32'(a) / (32'd1 << sh));
            default: return a;
        endcase
    endfunction

    task automatic check(input string tag,
                         input logic [15:0] obs,
                         input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic wr(input logic [2:0] ad, input logic [15:0] d);
        @(negedge clk);
        address_a    = ad;
        write_data   = d;
        write_enable = 1'b1;
        @(posedge clk);
        #1;
        write_enable = 1'b0;
        model[ad]    = d;
    endtask

    task automatic alu_at(input logic [2:0] aa, input logic [2:0] ab,
                          input logic [3:0] op);
        @(negedge clk);
        address_a = aa;
        address_b = ab;
        opcode    = op;
        #1;
    endtask

    initial begin
        logic [15:0] exp;
        rst_n        = 1'b1;
        opcode       = 4'd0;
        address_a    = '0;
        address_b    = '0;
        write_enable = 1'b0;
        write_data   = '0;
        for (int i = 0; i < 8; i++) wr(3'(i), 16'($urandom));

        // Mid-cycle reset pulse, reads checked with no clock edge
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        for (int i = 0; i < 8; i++) begin
            address_a = 3'(i);
            address_b = 3'(7 - i);
            #0.2;
            check($sformatf("rst_a%0d", i), data_a, 16'h0000);
            check($sformatf("rst_b%0d", i), data_b, 16'h0000);
        end
        for (int i = 0; i < 8; i++) model[i] = '0;
        opcode = 4'd7;
        #0.2;
        check("rst_not", alu_result, 16'hFFFF);
        check("rst_not_z", 16'(zero), 16'd0);
        opcode = 4'd2;
        #0.2;
        check("rst_add_z", 16'(zero), 16'd1);
        // Writes ignored while held in reset
        address_a    = 3'd2;
        write_data   = 16'h7777;
        write_enable = 1'b1;
        @(posedge clk);
        #1;
        write_enable = 1'b0;
        check("rst_nowr", data_a, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic write then ALU
        wr(3'd1, 16'h0005);
        wr(3'd2, 16'h0003);
        alu_at(3'd1, 3'd2, 4'b0010);
        check("add", alu_result, 16'h0008);
        check("add_z", 16'(zero), 16'd0);
        alu_at(3'd1, 3'd2, 4'b0011);
        check("sub", alu_result, 16'h0002);

        wr(3'd3, 16'h1234);
        alu_at(3'd3, 3'd3, 4'b0011);
        check("sub_eq", alu_result, 16'h0000);
        check("sub_eq_z", 16'(zero), 16'd1);

        wr(3'd4, 16'hFFFF);
        wr(3'd5, 16'h0001);
        alu_at(3'd4, 3'd5, 4'b0010);
        check("add_wrap", alu_result, 16'h0000);
        check("add_wrap_z", 16'(zero), 16'd1);
        alu_at(3'd5, 3'd4, 4'b0011);
        check("sub_wrap", alu_result, 16'h0002);
        alu_at(3'd0, 3'd5, 4'b0011);
        check("sub_borrow", alu_result, 16'hFFFF);
        check("sub_borrow_z", 16'(zero), 16'd0);

        // Read during write: old value before edge, new value after
        @(negedge clk);
        address_a    = 3'd6;
        write_data   = 16'hBEEF;
        write_enable = 1'b1;
        #1;
        check("rdw_before", data_a, 16'h0000);
        @(posedge clk);
        #1;
        check("rdw_after", data_a, 16'hBEEF);
        write_enable = 1'b0;
        write_data   = 16'h1234;
        @(posedge clk);
        #1;
        check("rdw_hold", data_a, 16'hBEEF);
        model[6] = 16'hBEEF;

        // Reset coincident with a write
        @(negedge clk);
        address_a    = 3'd7;
        write_data   = 16'h00AA;
        write_enable = 1'b1;
        @(posedge clk);
        rst_n = 1'b0;
        #1;
        write_enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) model[i] = '0;
        #1;
        check("rst_wr_r7", data_a, 16'h0000);
        address_a = 3'd6;
        #1;
        check("rst_clr_r6", data_a, 16'h0000);

        // First edge after release accepts a write
        wr(3'd0, 16'h0055);
        check("post_rst_wr", data_a, 16'h0055);

        // Randomized traffic against the model
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            address_a    = 3'($urandom);
            address_b    = 3'($urandom);
            opcode       = 4'($urandom);
            write_data   = 16'($urandom);
            write_enable = 1'($urandom);
            #1;
            exp = ref_alu(opcode, model[address_a], model[address_b]);
            check($sformatf("rnd%0d_a", n), data_a, model[address_a]);
            check($sformatf("rnd%0d_b", n), data_b, model[address_b]);
            check($sformatf("rnd%0d_res", n), alu_result, exp);
            check($sformatf("rnd%0d_z", n), 16'(zero), 16'(exp == 16'd0));
            @(posedge clk);
            if (write_enable) model[address_a] = write_data;
            #1;
            write_enable = 1'b0;
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/alu_regfile.md
ALU_REGFILE -- requirements
Module: alu_regfile

Interface
REQ-001 Parameter DATA_W, default 16: register and datapath width in bits.
REQ-002 Parameter ADDR_W, default 3: register address width, giving 2**ADDR_W = 8 registers.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 Port opcode, input, 4: ALU operation select.
REQ-006 Port address_a, input, ADDR_W: read port A address; also the write address.
REQ-007 Port address_b, input, ADDR_W: read port B address.
REQ-008 Port write_enable, input, 1: write write_data into register[address_a] on the next rising clk edge.
REQ-009 Port write_data, input, DATA_W: register write value.
REQ-010 Port data_a, output, DATA_W: contents of register[address_a].
REQ-011 Port data_b, output, DATA_W: contents of register[address_b].
REQ-012 Port alu_result, output, DATA_W: ALU result computed from data_a (operand a) and data_b (operand b).
REQ-013 Port zero, output, 1: high when alu_result equals 0.

Function
REQ-014 The register file SHALL hold 8 x DATA_W registers; all are general purpose, including register 0, and all are writable.
REQ-015 Reads SHALL be combinational:
- data_a and data_b follow their addresses within the same cycle.
- Both ports may address the same register.
REQ-016 A write SHALL occur on a rising clk edge when write_enable=1 and rst_n=1; the target is register[address_a].
REQ-017 Write timing and bypass:
- In the write cycle, reads return the old value (no write-through bypass).
- The new value is visible immediately after the edge.
REQ-018 write_enable=0 SHALL leave all registers unchanged.
REQ-019 The ALU SHALL be purely combinational with 0-cycle latency from opcode, data_a or data_b.
REQ-020 ALU opcodes, all arithmetic modulo 2**DATA_W with carry/borrow discarded:
- 0001 LOADI: result = b.
- 0010 ADD: result = a + b.
- 0011 SUB: result = a - b.
- 0100 AND: result = a & b.
- 0101 OR: result = a | b.
- 0110 XOR: result = a ^ b.
- 0111 NOT: result = ~a.
- 1001 SHL: result = a << b[3:0].
- 1010 SHR: result = a >> b[3:0], logical.
- All other opcodes, including 0000, 1000, 1100 and 1111: result = a (pass-through).
REQ-021 zero SHALL equal (alu_result == 0) for every opcode, updating combinationally.
REQ-022 Wrap-around: ADD 0xFFFF + 0x0001 gives 0x0000 with zero=1; SUB 0x0000 - 0x0001 gives 0xFFFF with zero=0.
REQ-023 SUB with a == b SHALL give alu_result=0 and zero=1.
REQ-024 The block SHALL contain no hidden status register; any flag storage belongs to the instantiating processor.

Reset
REQ-025 Asserting rst_n=0 SHALL immediately clear all 8 registers to 0, independent of clk.
REQ-026 While rst_n=0, writes SHALL be ignored.
REQ-027 While rst_n=0, data_a and data_b SHALL read 0, alu_result follows REQ-020 on zero operands, and zero=1 except for NOT (zero=0).
REQ-028 Reset asserted in the same cycle as a write SHALL win: the register reads 0 afterwards.
REQ-029 After rst_n deasserts, the first write SHALL take effect on the first rising clk edge on which rst_n is high.

Structure
REQ-030 Opcode encodings and the DATA_W/ADDR_W defaults SHALL live in a shared package, alu_regfile_pkg.
REQ-031 The combinational ALU SHALL be one sub-module, alu_core; register storage stays in alu_regfile.

Verification
REQ-032 Reset then read: pulse rst_n low mid-cycle -> all 8 registers read 0x0000 on both ports without any clk edge.
REQ-033 Write then read: write 0x0005 to r1 and 0x0003 to r2; set address_a=1, address_b=2, opcode=0010 -> alu_result=0x0008, zero=0; opcode=0011 -> alu_result=0x0002.
REQ-034 Zero flag on SUB: r3=0x1234, address_a=address_b=3, opcode=0011 -> alu_result=0x0000, zero=1.
REQ-035 Wrap-around: r4=0xFFFF, r5=0x0001, ADD -> alu_result=0x0000, zero=1; SUB with a=r5, b=r4 -> alu_result=0x0002.
REQ-036 Read during write: write_enable=1, address_a=6, write_data=0xBEEF, r6 previously 0x0000 -> data_a=0x0000 before the edge, 0xBEEF after; write_enable=0 on the next edge leaves 0xBEEF.
REQ-037 Reset mid-write: assert rst_n=0 coincident with a write of 0x00AA to r7 -> r7 reads 0x0000 after reset releases.
